// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | muldiv_sequencer_pkg                                                  |
// | Operation codes and FSM states for the MULT/DIV sequencer.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package muldiv_sequencer_pkg;

   localparam logic [1:0] MD_NONE = 2'b00;
   localparam logic [1:0] MD_MULT = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_FIX  = 2'b10,
      MD_DONE = 2'b11
   } md_state_e;

   function automatic logic md_op_valid(input logic [1:0] op_code);
      return (op_code == MD_MULT) || (op_code == MD_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | muldiv_sequencer                                                      |
// | Bit-serial signed MULT/DIV owning the HI/LO register pair.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  div_by_zero
);

   localparam int W = DATA_WIDTH;

   function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
      return v[W-1] ? -v : v;
   endfunction

   function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   md_state_e              state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [1:0]             op_q, op_d;
   logic                   sign1_q, sign1_d;
   logic                   sign2_q, sign2_d;
   logic [W-1:0]           mag1_q, mag1_d;
   logic [W-1:0]           mag2_q, mag2_d;
   // MULT: {partial product, remaining multiplier bits}; DIV: lower half holds the quotient
   logic [2*W-1:0]         acc_q, acc_d;
   logic [W-1:0]           rem_q, rem_d;
   logic [W-1:0]           hi_q, hi_d;
   logic [W-1:0]           lo_q, lo_d;
   logic                   dbz_q, dbz_d;

   logic [W:0]             add_sum;
   logic [W:0]             div_shift;
   logic [W:0]             div_diff;
   logic [2*W-1:0]         prod_fix;
   logic                   accept;

   assign add_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag1_q} : '0);
   assign div_shift = {rem_q, acc_q[W-1]};
   // Borrow out of the W+1 bit subtract marks a failed trial subtraction
   assign div_diff  = div_shift - {1'b0, mag2_q};
   assign prod_fix  = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
   assign accept    = start && md_op_valid(op);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      sign1_d = sign1_q;
      sign2_d = sign2_q;
      mag1_d  = mag1_q;
      mag2_d  = mag2_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;

      case (state_q)
         MD_IDLE, MD_DONE: begin
            dbz_d   = 1'b0;
            state_d = MD_IDLE;
            if (accept) begin
               op_d    = op;
               sign1_d = in1[W-1];
               sign2_d = in2[W-1];
               mag1_d  = abs_val(in1);
               mag2_d  = abs_val(in2);
               acc_d   = {{W{1'b0}}, (op == MD_MULT) ? abs_val(in2) : abs_val(in1)};
               rem_d   = '0;
               cnt_d   = CNT_WIDTH'(W);
               state_d = MD_CALC;
            end
         end
         MD_CALC: begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (op_q == MD_MULT) begin
               acc_d = {add_sum, acc_q[W-1:1]};
            end else begin
               acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_diff[W]};
               rem_d = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
            end
            if (cnt_q == CNT_WIDTH'(1)) begin
               state_d = MD_FIX;
            end
         end
         MD_FIX: begin
            state_d = MD_DONE;
            if (op_q == MD_MULT) begin
               hi_d = prod_fix[2*W-1:W];
               lo_d = prod_fix[W-1:0];
            end else if (mag2_q == '0) begin
               dbz_d = 1'b1;
            end else begin
               lo_d = neg_if(acc_q[W-1:0], sign1_q ^ sign2_q);
               hi_d = neg_if(rem_q, sign1_q);
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_NONE;
         sign1_q <= 1'b0;
         sign2_q <= 1'b0;
         mag1_q  <= '0;
         mag2_q  <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sign1_q <= sign1_d;
         sign2_q <= sign2_d;
         mag1_q  <= mag1_d;
         mag2_q  <= mag2_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == MD_CALC) || (state_q == MD_FIX);
   assign done        = (state_q == MD_DONE);
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
